// File: rtl/seg7_pkg.sv
// seg7_pkg: glyph constants, nibble width and reader state type shared by the seg7 checkers
package seg7_pkg;
  localparam int NIB_W = 4;
  localparam logic [6:0] SEG7_GLYPH_0 = 7'b0000001;
  localparam logic [6:0] SEG7_GLYPH_1 = 7'b1001111;
  localparam logic [6:0] SEG7_GLYPH_2 = 7'b0010010;
  localparam logic [6:0] SEG7_GLYPH_3 = 7'b0000110;
  localparam logic [6:0] SEG7_GLYPH_4 = 7'b1001100;
  localparam logic [6:0] SEG7_GLYPH_5 = 7'b0100100;
  localparam logic [6:0] SEG7_GLYPH_6 = 7'b0100000;
  localparam logic [6:0] SEG7_GLYPH_7 = 7'b0001111;
  localparam logic [6:0] SEG7_GLYPH_8 = 7'b0000000;
  localparam logic [6:0] SEG7_GLYPH_9 = 7'b0000100;
  localparam logic [6:0] SEG7_GLYPH_A = 7'b0000010;
  localparam logic [6:0] SEG7_GLYPH_B = 7'b1100000;
  localparam logic [6:0] SEG7_GLYPH_C = 7'b0110001;
  localparam logic [6:0] SEG7_GLYPH_D = 7'b1000010;
  localparam logic [6:0] SEG7_GLYPH_E = 7'b0010000;
  localparam logic [6:0] SEG7_GLYPH_F = 7'b0111000;
  localparam logic [6:0] SEG7_BLANK   = 7'b1111111;
  typedef enum logic [1:0] {IDLE, SETTLING, SAMPLED} rd_state_e;
endpackage

// File: rtl/seg7_glyph_decode.sv
// seg7_glyph_decode: active-low abcdefg pattern back to a hex nibble, flagging non-glyphs (blank included)
module seg7_glyph_decode
  import seg7_pkg::*;
(
  input  logic [6:0]       seg_n_i,
  output logic [NIB_W-1:0] nibble_o,
  output logic             bad_o
);
  // table lookup; anything that is not one of the sixteen glyphs reads as 0 and bad
  always_comb begin
    nibble_o = '0;
    bad_o = 1'b0;
    case (seg_n_i)
      SEG7_GLYPH_0: nibble_o = 4'h0;
      SEG7_GLYPH_1: nibble_o = 4'h1;
      SEG7_GLYPH_2: nibble_o = 4'h2;
      SEG7_GLYPH_3: nibble_o = 4'h3;
      SEG7_GLYPH_4: nibble_o = 4'h4;
      SEG7_GLYPH_5: nibble_o = 4'h5;
      SEG7_GLYPH_6: nibble_o = 4'h6;
      SEG7_GLYPH_7: nibble_o = 4'h7;
      SEG7_GLYPH_8: nibble_o = 4'h8;
      SEG7_GLYPH_9: nibble_o = 4'h9;
      SEG7_GLYPH_A: nibble_o = 4'hA;
      SEG7_GLYPH_B: nibble_o = 4'hB;
      SEG7_GLYPH_C: nibble_o = 4'hC;
      SEG7_GLYPH_D: nibble_o = 4'hD;
      SEG7_GLYPH_E: nibble_o = 4'hE;
      SEG7_GLYPH_F: nibble_o = 4'hF;
      default:      bad_o = 1'b1;
    endcase
  end
endmodule

// File: rtl/seg7_scan_reader.sv
// seg7_scan_reader: reads a multiplexed active-low 7-seg bus back into hex frames; SEG7_SCAN_READER_SYNC_EN adds input synchronizers
module seg7_scan_reader
  import seg7_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int SETTLE = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DIGITS-1:0]       an_n,
  input  logic [6:0]              seg_n,
  output logic [NIB_W*DIGITS-1:0] frame_value,
  output logic [DIGITS-1:0]       frame_bad,
  output logic                    frame_valid,
  input  logic                    frame_ready,
  output logic                    overrun
);
  localparam int CW = $clog2(SETTLE + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(SETTLE);
  logic [DIGITS-1:0] an_s;
  logic [6:0] seg_s;
`ifdef SEG7_SCAN_READER_SYNC_EN
  logic [DIGITS-1:0] an_m_q, an_s_q;
  logic [6:0] seg_m_q, seg_s_q;
  // two-flop synchronizers; all ones out of reset reads as an idle bus
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      {an_m_q, seg_m_q, an_s_q, seg_s_q} <= '1;
    end else begin
      {an_m_q, seg_m_q} <= {an_n, seg_n};
      {an_s_q, seg_s_q} <= {an_m_q, seg_m_q};
    end
  end
  assign an_s = an_s_q;
  assign seg_s = seg_s_q;
`else
  assign an_s = an_n;
  assign seg_s = seg_n;
`endif
  logic [DIGITS-1:0] an_p_q;
  logic [6:0] seg_p_q;
  rd_state_e state_q;
  logic [CW-1:0] cnt_q;
  logic [NIB_W-1:0] nib;
  logic bad;
  logic qual, changed, sample, complete;
  logic [DIGITS-1:0] mask_q, mask_set, mask_nx, slot_bad_q, bad_nx;
  logic [NIB_W*DIGITS-1:0] slot_val_q, val_nx;
  seg7_glyph_decode u_dec (
    .seg_n_i  (seg_s),
    .nibble_o (nib),
    .bad_o    (bad)
  );
  assign qual = $onehot(~an_s);
  assign changed = {an_s, seg_s} != {an_p_q, seg_p_q};
  assign sample = state_q == SETTLING && !changed && cnt_q == CNT_MAX - 1'b1;
  assign mask_set = sample ? ~an_s : '0;
  assign mask_nx = mask_q | mask_set;
  assign complete = sample && &mask_nx;
  // slot contents with the digit being sampled this cycle merged in
  always_comb begin
    val_nx = slot_val_q;
    bad_nx = slot_bad_q;
    for (int d = 0; d < DIGITS; d++) begin
      val_nx[NIB_W*d+:NIB_W] = mask_set[d] ? nib : slot_val_q[NIB_W*d+:NIB_W];
      bad_nx[d] = mask_set[d] ? bad : slot_bad_q[d];
    end
  end
  // settle tracker: count consecutive identical qualified bus cycles, sample once per stable digit
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      an_p_q <= '1;
      seg_p_q <= '1;
    end else begin
      an_p_q <= an_s;
      seg_p_q <= seg_s;
      if (state_q == IDLE || changed) begin
        state_q <= qual ? SETTLING : IDLE;
        cnt_q <= qual ? CW'(1) : '0;
      end else if (state_q == SETTLING) begin
        state_q <= sample ? SAMPLED : SETTLING;
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end
  // frame assembly and output handshake; a completion that cannot be delivered is dropped
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_val_q <= '0;
      slot_bad_q <= '0;
      mask_q <= '0;
      frame_value <= '0;
      frame_bad <= '0;
      frame_valid <= 1'b0;
      overrun <= 1'b0;
    end else begin
      slot_val_q <= val_nx;
      slot_bad_q <= bad_nx;
      mask_q <= complete ? '0 : mask_nx;
      overrun <= complete && frame_valid && !frame_ready;
      if (complete && (!frame_valid || frame_ready)) begin
        frame_value <= val_nx;
        frame_bad <= bad_nx;
        frame_valid <= 1'b1;
      end else if (frame_ready) begin
        frame_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_seg7_scan_reader.sv
// tb_seg7_scan_reader: directed scans of the 7-seg bus with hand-computed frames
module tb_seg7_scan_reader;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] an_n = 4'b1111;
  logic [6:0] seg_n = 7'b1111111;
  logic frame_ready = 1'b0;
  logic [15:0] frame_value;
  logic [3:0] frame_bad;
  logic frame_valid, overrun;
  int n_vec = 0;
  int n_bad = 0;
  localparam logic [6:0] G [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0000010, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0010000, 7'b0111000
  };
  seg7_scan_reader dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .an_n        (an_n),
    .seg_n       (seg_n),
    .frame_value (frame_value),
    .frame_bad   (frame_bad),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .overrun     (overrun)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic show(input logic [3:0] an, input logic [6:0] seg, input int n);
    an_n = an;
    seg_n = seg;
    step(n);
  endtask
  task automatic digit(input int d, input logic [3:0] v, input int n);
    show(~(4'b0001 << d), G[v], n);
  endtask
  task automatic accept();
    frame_ready = 1'b1;
    step(1);
    frame_ready = 1'b0;
    check("accept_drop", 32'(frame_valid), 0);
  endtask
  initial begin
    step(2);
    check("rst_value", 32'(frame_value), 0);
    check("rst_bad", 32'(frame_bad), 0);
    check("rst_valid", 32'(frame_valid), 0);
    check("rst_overrun", 32'(overrun), 0);
    rst_n = 1'b1;
    digit(0, 4'd1, 40);
    digit(1, 4'd2, 40);
    digit(2, 4'd3, 40);
    digit(3, 4'd4, 15);
    check("t1_early", 32'(frame_valid), 0);
    step(1);
    check("t1_valid", 32'(frame_valid), 1);
    check("t1_value", 32'(frame_value), 'h4321);
    check("t1_bad", 32'(frame_bad), 0);
    step(24);
    accept();
    for (int k = 0; k < 6; k++) digit(0, k[0] ? 4'd2 : 4'd1, 15);
    check("t2_short_hold", 32'(frame_valid), 0);
    digit(1, 4'd5, 40);
    digit(2, 4'd6, 40);
    digit(3, 4'd7, 40);
    check("t2_no_frame", 32'(frame_valid), 0);
    digit(0, 4'd8, 40);
    check("t2_valid", 32'(frame_valid), 1);
    check("t2_value", 32'(frame_value), 'h7658);
    accept();
    digit(0, 4'd9, 40);
    digit(1, 4'd10, 40);
    show(4'b1011, 7'b1111111, 40);
    digit(3, 4'd12, 40);
    check("t3_valid", 32'(frame_valid), 1);
    check("t3_value", 32'(frame_value), 'hC0A9);
    check("t3_bad", 32'(frame_bad), 'b0100);
    accept();
    digit(0, 4'd1, 40);
    digit(1, 4'd2, 40);
    digit(2, 4'd3, 40);
    digit(3, 4'd4, 40);
    check("t4_first", 32'(frame_value), 'h4321);
    digit(0, 4'd5, 40);
    digit(1, 4'd6, 40);
    digit(2, 4'd7, 40);
    digit(3, 4'd8, 15);
    check("t4_ovr_early", 32'(overrun), 0);
    step(1);
    check("t4_ovr_pulse", 32'(overrun), 1);
    check("t4_keep_value", 32'(frame_value), 'h4321);
    check("t4_keep_valid", 32'(frame_valid), 1);
    step(1);
    check("t4_ovr_end", 32'(overrun), 0);
    step(20);
    check("t4_hold", 32'(frame_value), 'h4321);
    accept();
    show(4'b1100, G[1], 100);
    show(4'b1111, G[3], 100);
    check("t5_unqual", 32'(frame_valid), 0);
    digit(1, 4'd11, 40);
    digit(2, 4'd13, 40);
    digit(3, 4'd14, 40);
    check("t5_no_capture", 32'(frame_valid), 0);
    digit(0, 4'd15, 40);
    check("t5_valid", 32'(frame_valid), 1);
    check("t5_value", 32'(frame_value), 'hEDBF);
    digit(0, 4'd1, 40);
    digit(1, 4'd2, 40);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    check("t6_value", 32'(frame_value), 0);
    check("t6_bad", 32'(frame_bad), 0);
    check("t6_valid", 32'(frame_valid), 0);
    check("t6_overrun", 32'(overrun), 0);
    digit(2, 4'd3, 40);
    digit(3, 4'd4, 40);
    check("t6_partial_lost", 32'(frame_valid), 0);
    digit(0, 4'd5, 40);
    check("t6_need_d1", 32'(frame_valid), 0);
    digit(1, 4'd6, 40);
    check("t6_valid", 32'(frame_valid), 1);
    check("t6_frame", 32'(frame_value), 'h4365);
    accept();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
